// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-bit validation at mid-bit,
// LSB-first data capture and stop-bit check, all paced by an oversampling tick.
module uart_rx #(
    parameter int WIDTH_WORD    = 8,
    parameter int CANT_BIT_STOP = 1,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rate,
    input  logic                  i_bit_rx,
    output logic [WIDTH_WORD-1:0] o_data_out,
    output logic                  o_rx_done,
    output logic                  o_frame_error,
    output logic                  o_busy
);

    localparam int TICK_SPAN = CANT_BIT_STOP * TICKS_PER_BIT;
    localparam int TW        = $clog2(TICK_SPAN);
    localparam int BW        = $clog2(WIDTH_WORD + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_BIT  = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_STOP = TW'(TICK_SPAN - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_WORD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [WIDTH_WORD-1:0] r_shift;
    logic [WIDTH_WORD-1:0] r_data_out;
    logic                  r_rx_done;
    logic                  r_frame_error;

    state_t                w_state_next;
    logic [TW-1:0]         w_tick_next;
    logic [BW-1:0]         w_bit_next;
    logic [WIDTH_WORD-1:0] w_shift_next;
    logic [WIDTH_WORD-1:0] w_shift_in;
    logic                  w_frame_done;
    logic                  w_rx_s;

    assign w_rx_s = r_sync2;

    // New bit enters at the MSB so the first bit on the line ends up at the LSB.
    generate
        if (WIDTH_WORD == 1) begin : g_shift_one
            assign w_shift_in = w_rx_s;
        end else begin : g_shift_many
            assign w_shift_in = {w_rx_s, r_shift[WIDTH_WORD-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_rx_done     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_sync1    <= i_bit_rx;
            r_sync2    <= r_sync1;
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_rx_done  <= w_frame_done;
            if (w_frame_done) begin
                r_data_out    <= r_shift;
                r_frame_error <= ~w_rx_s;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                // Falling edge is acted on immediately, not on the next tick.
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_tick_next  = '0;
                end
            end
            START: begin
                if (i_rate) begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_rate) begin
                    if (r_tick_cnt == TICK_BIT) begin
                        w_tick_next  = '0;
                        w_bit_next   = r_bit_cnt + BW'(1);
                        w_shift_next = w_shift_in;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (i_rate) begin
                    if (r_tick_cnt == TICK_STOP) begin
                        w_tick_next  = '0;
                        w_frame_done = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_tick_next = r_tick_cnt + TW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != IDLE);
        o_data_out    = r_data_out;
        o_rx_done     = r_rx_done;
        o_frame_error = r_frame_error;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit from a word,
// and a queue of expected {frame_error, data} is matched against each rx_done.
module tb_uart_rx;

    localparam int W = 8;
    localparam int S = 1;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_rate;
    logic         i_bit_rx;
    logic [W-1:0] o_data_out;
    logic         o_rx_done;
    logic         o_frame_error;
    logic         o_busy;

    int errors = 0;
    int checks = 0;
    int rate_div = 4;
    int n_done = 0;
    int n_exp = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] last_data = '0;

    uart_rx #(.WIDTH_WORD(W), .CANT_BIT_STOP(S), .TICKS_PER_BIT(T)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_rate       (i_rate),
        .i_bit_rx     (i_bit_rx),
        .o_data_out   (o_data_out),
        .o_rx_done    (o_rx_done),
        .o_frame_error(o_frame_error),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick source: one pulse every rate_div clocks, or continuously high.
    initial begin
        int cnt = 0;
        i_rate = 1'b0;
        forever begin
            @(negedge clk);
            if (rate_div <= 1) begin
                i_rate = 1'b1;
            end else begin
                cnt    = (cnt + 1) % rate_div;
                i_rate = (cnt == 0);
            end
        end
    end

    // Scoreboard: every pulse must be expected, one clock wide, and carry the right word.
    initial begin
        logic       prev_done = 1'b0;
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (o_rx_done === 1'b1) begin
                n_done++;
                chk("done_width", {31'b0, prev_done}, 32'd0);
                chk("pending_frame", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_data", {24'b0, o_data_out}, {24'b0, e[W-1:0]});
                    chk("frame_err", {31'b0, o_frame_error}, {31'b0, e[W]});
                    $display("frame %0d: data=%02h frame_error=%0b", n_done, o_data_out, o_frame_error);
                end
            end
            prev_done = o_rx_done;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            do @(posedge clk); while (i_rate !== 1'b1);
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic bad_stop);
        exp_q.push_back({bad_stop, data});
        n_exp++;
        last_data = data;
        i_bit_rx = 1'b0;
        wait_ticks(T);
        for (int b = 0; b < W; b++) begin
            i_bit_rx = (data >> b) & 1;
            wait_ticks(T);
        end
        if (bad_stop) begin
            // Low across the stop sample, then idle long enough to clear the break.
            i_bit_rx = 1'b0;
            wait_ticks(S * T - 4);
            i_bit_rx = 1'b1;
            wait_ticks(4 + T);
        end else begin
            i_bit_rx = 1'b1;
            wait_ticks(S * T);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, {24'b0, o_data_out}, 32'd0);
        chk({tag, "_done"}, {31'b0, o_rx_done}, 32'd0);
        chk({tag, "_ferr"}, {31'b0, o_frame_error}, 32'd0);
        chk({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        logic         busy_seen;
        logic [W-1:0] rnd;
        logic         bad;

        // Reset and idle line
        i_reset  = 1'b1;
        i_bit_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        busy_seen = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (o_busy) busy_seen = 1'b1;
        end
        chk("idle_busy", {31'b0, busy_seen}, 32'd0);
        chk("idle_data", {24'b0, o_data_out}, 32'd0);
        chk("idle_frames", n_done, 32'd0);

        // Single frame, then back-to-back extremes
        send_frame(8'hA5, 1'b0);
        chk("frame_count_a5", n_done, n_exp);
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        chk("frame_count_b2b", n_done, n_exp);
        chk("b2b_last_data", {24'b0, o_data_out}, {24'b0, last_data});

        // Short low glitch must be rejected without touching outputs
        i_bit_rx = 1'b0;
        wait_ticks(5);
        i_bit_rx = 1'b1;
        wait_ticks(T);
        chk("glitch_busy", {31'b0, o_busy}, 32'd0);
        chk("glitch_data", {24'b0, o_data_out}, {24'b0, last_data});
        chk("glitch_frames", n_done, n_exp);
        send_frame(8'h3C, 1'b0);

        // Framing error then recovery
        send_frame(8'h5A, 1'b1);
        chk("ferr_set", {31'b0, o_frame_error}, 32'd1);
        send_frame(8'h96, 1'b0);
        chk("ferr_clear", {31'b0, o_frame_error}, 32'd0);
        chk("frame_count_ferr", n_done, n_exp);

        // Reset during data bit 4 discards the partial frame
        i_bit_rx = 1'b0;
        wait_ticks(T);
        for (int b = 0; b < 4; b++) begin
            i_bit_rx = b[0];
            wait_ticks(T);
        end
        i_bit_rx = 1'b0;
        wait_ticks(T / 2);
        @(negedge clk);
        i_reset  = 1'b1;
        i_bit_rx = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_reset_outputs("midreset");
        last_data = '0;
        wait_ticks(2 * T * (W + 2));
        chk("midreset_frames", n_done, n_exp);
        chk("midreset_data", {24'b0, o_data_out}, 32'd0);
        send_frame(8'h81, 1'b0);
        chk("frame_count_81", n_done, n_exp);

        // Random frames at 4 clocks per tick
        for (int i = 0; i < 6; i++) begin
            rnd = W'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(rnd, bad);
        end
        chk("frame_count_rand4", n_done, n_exp);

        // Tick held high: one clock per tick
        wait_ticks(T);
        rate_div = 1;
        wait_ticks(T);
        send_frame(8'hA5, 1'b0);
        chk("rate_high_data", {24'b0, o_data_out}, 32'hA5);
        for (int i = 0; i < 6; i++) begin
            rnd = W'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(rnd, bad);
        end
        wait_ticks(T);
        chk("frame_count_final", n_done, n_exp);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_busy", {31'b0, o_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
